// File: rtl/alp_mdseq_pkg.sv
// rtl/alp_mdseq_pkg.sv - shared ALU codes, op codes, state and shift encodings for alp_mdseq
package alp_mdseq_pkg;

  // ALU function codes; must stay aligned with the ALU control decode
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_XOR    = 4'h3;
  localparam logic [3:0] ALU_ADD_SR = 4'h8;
  localparam logic [3:0] ALU_ADD_SL = 4'h9;
  localparam logic [3:0] ALU_SUB_SL = 4'hA;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_DIV = 2'b01,
    OP_BCD = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_STEP = 3'd2,
    S_FIX  = 3'd3,
    S_BCD  = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/alp_mdseq_stepctr.sv
// rtl/alp_mdseq_stepctr.sv - loadable down-counter for iteration steps, saturates at zero
module alp_mdseq_stepctr #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset_h,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset_h) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alp_mdseq.sv
// rtl/alp_mdseq.sv - multi-cycle MUL/DIV/BCD sequencer driving ALU control and AQ shifting
module alp_mdseq
  import alp_mdseq_pkg::*;
#(
  parameter int STEPS = 32,
  parameter int CW    = 6
) (
  input  logic       clk,
  input  logic       reset_h,
  input  logic       start_h,
  input  logic [1:0] op_h,
  input  logic       stall_h,
  input  logic       abort_h,
  input  logic       q_lsb_h,
  input  logic       alu_sign_h,
  input  logic       div_zero_h,
  output logic [3:0] alu_h,
  output logic       pass_a_h,
  output logic       bcd_op_l,
  output logic [1:0] shift_ctl_h,
  output logic       q_in_h,
  output logic       ld_acc_h,
  output logic       busy_h,
  output logic       done_h,
  output logic       err_h
);

  state_e state;
  op_e    op_q;
  logic   err_q;
  logic   sign_q;
  logic   cnt_zero;
  logic   kill;

  // Abort only cancels working states; DONE always completes its pulse
  assign kill = abort_h && !stall_h &&
                (state inside {S_INIT, S_STEP, S_FIX, S_BCD});

  alp_mdseq_stepctr #(.CW(CW)) u_stepctr (
    .clk      (clk),
    .reset_h  (reset_h),
    .load     (!stall_h && (state == S_INIT)),
    .load_val (CW'(STEPS - 1)),
    .dec      (!stall_h && (state == S_STEP)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset_h) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
    end else if (!stall_h) begin
      if (kill) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start_h) begin
            op_q  <= op_e'(op_h);
            err_q <= (op_h == OP_RSV) || ((op_h == OP_DIV) && div_zero_h);
            state <= S_INIT;
          end
          S_INIT: begin
            sign_q <= 1'b0;
            if (err_q)                state <= S_DONE;
            else if (op_q == OP_BCD)  state <= S_BCD;
            else                      state <= S_STEP;
          end
          S_STEP: begin
            if (op_q == OP_DIV) sign_q <= alu_sign_h;
            if (cnt_zero) state <= (op_q == OP_DIV) ? S_FIX : S_DONE;
          end
          S_FIX:   state <= S_DONE;
          S_BCD:   state <= S_DONE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    alu_h       = ALU_ADD;
    pass_a_h    = 1'b1;
    bcd_op_l    = 1'b1;
    shift_ctl_h = SH_HOLD;
    q_in_h      = 1'b0;
    ld_acc_h    = 1'b0;
    busy_h      = (state != S_IDLE);
    done_h      = 1'b0;
    err_h       = 1'b0;
    case (state)
      S_INIT: begin
        alu_h    = ALU_XOR;
        pass_a_h = 1'b0;
        ld_acc_h = 1'b1;
      end
      S_STEP: begin
        ld_acc_h = 1'b1;
        if (op_q == OP_DIV) begin
          // Non-restoring: subtract while partial remainder is non-negative
          alu_h       = sign_q ? ALU_ADD_SL : ALU_SUB_SL;
          pass_a_h    = 1'b0;
          shift_ctl_h = SH_LEFT;
          q_in_h      = !sign_q;
        end else begin
          alu_h       = ALU_ADD_SR;
          pass_a_h    = !q_lsb_h;
          shift_ctl_h = SH_RIGHT;
        end
      end
      S_FIX: begin
        pass_a_h    = 1'b0;
        shift_ctl_h = SH_LEFT;
        q_in_h      = !sign_q;
        ld_acc_h    = sign_q;
      end
      S_BCD: begin
        pass_a_h = 1'b0;
        bcd_op_l = 1'b0;
        ld_acc_h = 1'b1;
      end
      S_DONE: begin
        done_h = 1'b1;
        err_h  = err_q;
      end
      default: ;
    endcase
    if (kill) ld_acc_h = 1'b0;
  end

endmodule

// File: tb/tb_alp_mdseq.sv
// tb/tb_alp_mdseq.sv - self-checking bench for alp_mdseq with STEPS=4
module tb_alp_mdseq;
  import alp_mdseq_pkg::*;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset_h, start_h, stall_h, abort_h, q_lsb_h, alu_sign_h, div_zero_h;
  logic [1:0] op_h;
  logic [3:0] alu_h;
  logic       pass_a_h, bcd_op_l, q_in_h, ld_acc_h, busy_h, done_h, err_h;
  logic [1:0] shift_ctl_h;

  always #5 clk = ~clk;

  alp_mdseq #(.STEPS(S), .CW(3)) dut (
    .clk(clk), .reset_h(reset_h), .start_h(start_h), .op_h(op_h),
    .stall_h(stall_h), .abort_h(abort_h), .q_lsb_h(q_lsb_h),
    .alu_sign_h(alu_sign_h), .div_zero_h(div_zero_h),
    .alu_h(alu_h), .pass_a_h(pass_a_h), .bcd_op_l(bcd_op_l),
    .shift_ctl_h(shift_ctl_h), .q_in_h(q_in_h), .ld_acc_h(ld_acc_h),
    .busy_h(busy_h), .done_h(done_h), .err_h(err_h)
  );

  typedef struct packed {
    logic [3:0] alu; logic pass; logic bcd_l; logic [1:0] sh;
    logic qin; logic ld; logic busy; logic done; logic err;
  } exp_t;

  typedef struct {
    logic start; logic [1:0] op; logic dz; logic stall; logic abort;
    logic rst; logic q; logic sg; exp_t e; string tag;
  } ent_t;

  ent_t sq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(logic [3:0] alu, logic pass, logic bcd_l, logic [1:0] sh,
                              logic qin, logic ld, logic busy, logic done, logic err);
    exp_t r;
    r = {alu, pass, bcd_l, sh, qin, ld, busy, done, err};
    return r;
  endfunction

  function automatic exp_t e_idle();
    return mk(ALU_ADD, 1'b1, 1'b1, SH_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t e_done(logic err);
    return mk(ALU_ADD, 1'b1, 1'b1, SH_HOLD, 1'b0, 1'b0, 1'b1, 1'b1, err);
  endfunction

  function automatic ent_t ent(string tag, exp_t e);
    ent_t x;
    x.tag = tag; x.e = e; x.start = 1'b0; x.op = 2'b00; x.dz = 1'b0;
    x.stall = 1'b0; x.abort = 1'b0; x.rst = 1'b0;
    x.q = 1'($urandom); x.sg = 1'($urandom);
    return x;
  endfunction

  // Expected cycle-by-cycle behaviour of one operation, starting at the accept cycle
  task automatic build(input logic [1:0] op, input logic dz, input logic [63:0] bits);
    ent_t x;
    logic prev;
    sq.delete();
    x = ent("accept", e_idle()); x.start = 1'b1; x.op = op; x.dz = dz;
    sq.push_back(x);
    sq.push_back(ent("init", mk(ALU_XOR, 1'b0, 1'b1, SH_HOLD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));
    if (op == 2'b11 || (op == 2'b01 && dz)) begin
      sq.push_back(ent("done_err", e_done(1'b1)));
    end else if (op == 2'b10) begin
      sq.push_back(ent("bcd", mk(ALU_ADD, 1'b0, 1'b0, SH_HOLD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)));
      sq.push_back(ent("done", e_done(1'b0)));
    end else if (op == 2'b00) begin
      for (int i = 0; i < S; i++) begin
        x = ent("mul_step", mk(ALU_ADD_SR, ~bits[i], 1'b1, SH_RIGHT, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        x.q = bits[i];
        sq.push_back(x);
      end
      sq.push_back(ent("done", e_done(1'b0)));
    end else begin
      // quotient bit is the complement of the previous remainder sign
      prev = 1'b0;
      for (int i = 0; i < S; i++) begin
        x = ent("div_step", mk(prev ? ALU_ADD_SL : ALU_SUB_SL, 1'b0, 1'b1, SH_LEFT,
                               ~prev, 1'b1, 1'b1, 1'b0, 1'b0));
        x.sg = bits[i];
        sq.push_back(x);
        prev = bits[i];
      end
      sq.push_back(ent("fix", mk(ALU_ADD, 1'b0, 1'b1, SH_LEFT, ~prev, prev, 1'b1, 1'b0, 1'b0)));
      sq.push_back(ent("done", e_done(1'b0)));
    end
    sq.push_back(ent("idle_after", e_idle()));
  endtask

  task automatic run(input string name);
    exp_t obs;
    for (int i = 0; i < sq.size(); i++) begin
      reset_h    = sq[i].rst;
      start_h    = sq[i].start;
      op_h       = sq[i].op;
      div_zero_h = sq[i].dz;
      stall_h    = sq[i].stall;
      abort_h    = sq[i].abort;
      q_lsb_h    = sq[i].q;
      alu_sign_h = sq[i].sg;
      #4;
      obs = {alu_h, pass_a_h, bcd_op_l, shift_ctl_h, q_in_h, ld_acc_h, busy_h, done_h, err_h};
      checks++;
      assert (obs === sq[i].e) else begin
        errors++;
        $error("FAIL %s[%0d] %s observed=%h expected=%h", name, i, sq[i].tag, obs, sq[i].e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    ent_t x;
    reset_h = 1'b1; start_h = 1'b0; op_h = 2'b00; stall_h = 1'b0; abort_h = 1'b0;
    q_lsb_h = 1'b0; alu_sign_h = 1'b0; div_zero_h = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_h = 1'b0;

    build(2'b00, 1'b0, 64'b1101);
    run("mul_dir");

    build(2'b01, 1'b0, 64'b0110);
    run("div_dir");

    build(2'b01, 1'b1, 64'h0);
    run("div_zero");

    build(2'b11, 1'b0, 64'h0);
    run("op_rsv");

    build(2'b10, 1'b0, 64'h0);
    sq[1].start = 1'b1; sq[2].start = 1'b1; sq[3].start = 1'b1;
    sq[3].abort = 1'b1;
    run("bcd_busy_start");

    build(2'b00, 1'b0, {$urandom, $urandom});
    x = sq[3]; x.stall = 1'b1;
    sq.insert(3, x); sq.insert(3, x);
    x.abort = 1'b1;
    sq.insert(3, x);
    x = sq[2 + S + 3]; x.stall = 1'b1;
    sq.insert(2 + S + 3, x); sq.insert(2 + S + 3, x);
    x = sq[0]; x.stall = 1'b1;
    sq.push_front(x);
    run("mul_stall");

    build(2'b00, 1'b0, {$urandom, $urandom});
    sq[3].abort = 1'b1;
    sq[3].e.ld  = 1'b0;
    while (sq.size() > 4) void'(sq.pop_back());
    sq.push_back(ent("idle_after_abort", e_idle()));
    run("mul_abort");

    build(2'b01, 1'b0, {$urandom, $urandom});
    sq[3].rst = 1'b1;
    while (sq.size() > 4) void'(sq.pop_back());
    sq.push_back(ent("after_reset", e_idle()));
    run("div_reset");

    for (int k = 0; k < 10; k++) begin
      build(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      run("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
